// File: rtl/dc608_wbus_rf_slice.sv
// 4-bit register-file slice: WBUS write-pending stage, 16x4 array, two registered active-low read ports.
// Optional odd-parity storage/checking is enabled by defining DC608_RF_PARITY_EN.
module dc608_wbus_rf_slice #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              rfck_l,
  input  logic              reset_h,
  input  logic [WIDTH-1:0]  wbus_h,
  input  logic [ADDR_W-1:0] wadr_h,
  input  logic              wen_l,
  input  logic [ADDR_W-1:0] radr_a_h,
  input  logic [ADDR_W-1:0] radr_b_h,
  input  logic              clr_h,
  output logic [WIDTH-1:0]  rbus_l,
  output logic [WIDTH-1:0]  mbus_l,
  output logic              busy_h,
  output logic              wdrop_h,
  output logic              perr_h
);

`ifdef DC608_RF_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  typedef enum logic {INIT, RUN} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt, cnt_nxt;
  logic [MW-1:0]       mem [DEPTH];
  logic                pend_v;
  logic [ADDR_W-1:0]   pend_adr;
  logic [WIDTH-1:0]    pend_dat;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_adr;
  logic [MW-1:0]       mem_din;
  logic [MW-1:0]       mem_a, mem_b;
  logic                wr_hit_a, wr_hit_b, pd_hit_a, pd_hit_b;
  logic [WIDTH-1:0]    data_a, data_b;
  logic                run_ok;

  assign busy_h = (state == INIT);
  assign run_ok = (state == RUN) && !clr_h;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      INIT: begin
        if (clr_h) cnt_nxt = '0;
        else begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == ADDR_W'(DEPTH-1)) state_nxt = RUN;
        end
      end
      RUN: if (clr_h) begin
        state_nxt = INIT;
        cnt_nxt   = '0;
      end
      default: state_nxt = INIT;
    endcase
  end

  // Array write port: INIT sweeps zeros, RUN commits the pending entry.
  always_comb begin
    mem_we  = 1'b0;
    mem_adr = pend_adr;
`ifdef DC608_RF_PARITY_EN
    mem_din = {~^pend_dat, pend_dat};
`else
    mem_din = pend_dat;
`endif
    if (state == INIT) begin
      mem_we  = 1'b1;
      mem_adr = cnt;
`ifdef DC608_RF_PARITY_EN
      mem_din = {1'b1, {WIDTH{1'b0}}};
`else
      mem_din = '0;
`endif
    end else if (run_ok && pend_v) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge rfck_l) begin
    if (mem_we) mem[mem_adr] <= mem_din;
  end

  assign mem_a    = mem[radr_a_h];
  assign mem_b    = mem[radr_b_h];
  assign wr_hit_a = !wen_l && (wadr_h == radr_a_h);
  assign wr_hit_b = !wen_l && (wadr_h == radr_b_h);
  assign pd_hit_a = pend_v && (pend_adr == radr_a_h);
  assign pd_hit_b = pend_v && (pend_adr == radr_b_h);

  // Write-first: the in-flight write beats the pending entry, which beats the array.
  assign data_a = wr_hit_a ? wbus_h : pd_hit_a ? pend_dat : mem_a[WIDTH-1:0];
  assign data_b = wr_hit_b ? wbus_h : pd_hit_b ? pend_dat : mem_b[WIDTH-1:0];

  always_ff @(posedge rfck_l or posedge reset_h) begin
    if (reset_h) begin
      state    <= INIT;
      cnt      <= '0;
      pend_v   <= 1'b0;
      pend_adr <= '0;
      pend_dat <= '0;
      rbus_l   <= '1;
      mbus_l   <= '1;
      wdrop_h  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      wdrop_h <= !wen_l && ((state == INIT) || clr_h);
      if (run_ok) begin
        pend_v   <= !wen_l;
        pend_adr <= wadr_h;
        pend_dat <= wbus_h;
        rbus_l   <= ~data_a;
        mbus_l   <= ~data_b;
      end else begin
        pend_v <= 1'b0;
        rbus_l <= '1;
        mbus_l <= '1;
      end
    end
  end

`ifdef DC608_RF_PARITY_EN
  logic err_a, err_b, perr_q;
  // Only array-sourced reads are checked; bypassed data never touched the array.
  assign err_a = !wr_hit_a && !pd_hit_a && !(^mem_a);
  assign err_b = !wr_hit_b && !pd_hit_b && !(^mem_b);

  always_ff @(posedge rfck_l or posedge reset_h) begin
    if (reset_h)                      perr_q <= 1'b0;
    else if (clr_h)                   perr_q <= 1'b0;
    else if (run_ok && (err_a || err_b)) perr_q <= 1'b1;
  end
  assign perr_h = perr_q;
`else
  assign perr_h = 1'b0;
`endif

endmodule

// File: doc/dc608_wbus_rf_slice.md
Name: dc608_wbus_rf_slice

Overview:
- 4-bit register-file slice that sits directly downstream of the ALP write bus.
- Captures WBUS results into a one-entry write-pending stage, then commits them to a 16x4 scratchpad array.
- Returns two read operands, active-low, onto RBUS and MBUS for the next ALP cycle.
- Includes a clear/init state machine that zeroes the array after reset or on command.

Parameters:
- WIDTH, 4, data bits per slice (matches ALP nibble).
- ADDR_W, 4, address width.
- DEPTH, 16, number of locations (2**ADDR_W).

Ports:
- rfck_l  input  1  slice clock; all state updates on its rising edge.
- reset_h  input  1  asynchronous active-high reset.
- wbus_h  input  WIDTH  write data from ALP wbus_h_out.
- wadr_h  input  ADDR_W  write address.
- wen_l  input  1  write request, active low.
- radr_a_h  input  ADDR_W  read address, port A (drives RBUS).
- radr_b_h  input  ADDR_W  read address, port B (drives MBUS).
- clr_h  input  1  start array clear.
- rbus_l  output  WIDTH  port A read data, active low.
- mbus_l  output  WIDTH  port B read data, active low.
- busy_h  output  1  high while in INIT.
- wdrop_h  output  1  one-cycle pulse: a write was discarded.
- perr_h  output  1  sticky parity error (see Optional Feature).

Behaviour:
- Clock and reset: single clock rfck_l; reset_h is asynchronous and active high.
- Reset values: rbus_l=mbus_l={WIDTH{1}} (reads as zero); busy_h=1; wdrop_h=0; perr_h=0; pend_v=0; state=INIT; init counter=0.
  - Array contents are not reset; INIT zeroes them.
- FSM INIT:
  - Each edge writes 0 to mem[cnt] and increments cnt.
  - After the edge writing DEPTH-1, goes to RUN with busy_h=0. INIT therefore lasts exactly DEPTH cycles.
  - Reads sampled in INIT return 0.
  - wen_l=0 in INIT: write discarded, wdrop_h=1 on the following cycle.
  - clr_h in INIT: restarts cnt at 0.
- FSM RUN:
  - clr_h=1 at an edge: go to INIT, cnt=0, busy_h=1.
  - Any pending entry is discarded, not committed.
  - A simultaneous write is discarded with a wdrop_h pulse.
- Write pipeline, at each RUN edge:
  - If pend_v, commit mem[pend_adr]<=pend_dat.
  - Then pend_v<=~wen_l, pend_adr<=wadr_h, pend_dat<=wbus_h.
  - Result: a write reaches the array one edge after capture. Back-to-back writes to any addresses are sustained every cycle.
- Reads: registered, 1-cycle latency.
  - Address sampled at edge N; data valid on rbus_l/mbus_l after edge N and held until the next edge.
  - Source priority per port, highest first:
    1. Same-edge write (wen_l=0 and wadr==radr): wbus_h.
    2. Valid pending entry with matching address: pend_dat.
    3. mem[radr].
  - Write-first semantics: a read never returns stale data.
- Both ports may address the same location; each resolves independently.
- Output encoding: rbus_l=~data_a, mbus_l=~data_b. Drive only; no tristate.
- Reset mid-operation: state returns to INIT, pending write lost, array re-zeroed.

Optional Feature:
- Macro: DC608_RF_PARITY_EN.
- When defined:
  - Array widens by one odd-parity bit per entry, computed from write data at commit; INIT writes parity 1.
  - Every array-sourced read (priority 3 only) checks parity. A mismatch sets perr_h on the same edge the data is registered.
  - perr_h is sticky until reset_h or clr_h.
- When undefined: no parity storage; perr_h tied 0.

Test Plan:
- Reset: reset_h pulse, no writes → busy_h=1 for exactly 16 edges; then reads of addresses 0..15 give rbus_l=mbus_l=4'hF.
- Basic write/read: write 4'hA to addr 3, idle 2 cycles, read A=3 B=3 → rbus_l=mbus_l=4'h5 one cycle after the address edge.
- Bypass:
  - Write 4'h6 to addr 7 with radr_a=7 on the same edge → rbus_l=4'h9.
  - Next edge write 4'hC to addr 7 with radr_b=7 → mbus_l=4'h3 (new write beats pending).
- Pending bypass: write 4'h1 to addr 2, next edge read A=2 with no write → rbus_l=4'hE; after one more edge mem[2]=1.
- Clear mid-run: write 4'hF to addr 5 and assert clr_h on the same edge → wdrop_h pulses; busy_h high for 16 cycles; then read 5 → rbus_l=4'hF. Assert reset_h during INIT → INIT restarts at cnt=0.
- Parity (DC608_RF_PARITY_EN only): write 4'h3 to addr 9, bench flips mem[9] bit 0, read A=9 → perr_h=1 and stays 1 until clr_h.
